// File: rtl/lcd_controller_pkg.sv
// Shared types and constants for the HD44780 character-LCD writer.
// The FSM state list covers both the fixed-wait build and the LCD_BUSY_POLL_EN build.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    WAIT,
    BF_SETUP,
    BF_EN,
    BF_HOLD
  } lcd_state_t;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Down-counter width able to hold (max_load - 1); never narrower than one bit.
  function automatic int cnt_width(input int max_load);
    return (max_load > 1) ? $clog2(max_load) : 1;
  endfunction

endpackage

// File: rtl/lcd_controller_if.sv
// CPU-side bus of the LCD writer: chip select, direction, register select and data.
interface lcd_controller_if;
  logic       chip_en;
  logic       write_en;
  logic [1:0] register_select;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output chip_en, write_en, register_select, data_in,
    input  data_out
  );

  modport slave (
    input  chip_en, write_en, register_select, data_in,
    output data_out
  );
endinterface

// File: rtl/lcd_controller_sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers; a pop frees a slot for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance; contents are discarded on reset by clearing both pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; no reset needed since empty/full come from the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/lcd_controller.sv
// Memory-mapped HD44780 writer: CPU bytes queue in a FIFO and are replayed onto
// the LCD pins with EN setup/pulse/hold timing. Define LCD_BUSY_POLL_EN to poll
// the busy flag (DB7) after each byte instead of waiting a fixed time.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int SETUP_CYCLES = 2,
  parameter int EN_CYCLES    = 12,
  parameter int HOLD_CYCLES  = 2,
  parameter int WAIT_CYCLES  = 2000
) (
  input  logic             clk,
  input  logic             reset_n,
  lcd_controller_if.slave  bus,
  output logic [7:0]       lcd_data_out,
  input  logic [7:0]       lcd_data_in,
  output logic             lcd_data_oe,
  output logic             lcd_en,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_on,
  output logic             lcd_blon
);
  localparam int PULSE_MAX = max2(max2(SETUP_CYCLES, EN_CYCLES), HOLD_CYCLES);
`ifdef LCD_BUSY_POLL_EN
  localparam int MAX_LD = PULSE_MAX;
  localparam int unused_wait_cycles = WAIT_CYCLES;
`else
  localparam int MAX_LD = max2(PULSE_MAX, 40 * WAIT_CYCLES);
`endif
  localparam int CNT_W = cnt_width(MAX_LD);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);

  lcd_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_cnt_zero;
  logic             r_rs;
  logic [7:0]       r_byte;
  logic             r_ovf;
  logic [1:0]       r_ctrl;
  logic             w_wr, w_push, w_pop, w_drop, w_stat_rd;
  logic             w_full, w_empty;
  logic [8:0]       w_din, w_dout;
  logic             w_unused;

  assign w_unused   = ^lcd_data_in;
  assign w_wr       = bus.chip_en && bus.write_en;
  assign w_push     = w_wr && ((bus.register_select == REG_CMD) || (bus.register_select == REG_DATA));
  assign w_din      = {(bus.register_select == REG_DATA), bus.data_in};
  assign w_drop     = w_push && w_full && !w_pop;
  assign w_stat_rd  = bus.chip_en && !bus.write_en && (bus.register_select == REG_STATUS);
  assign w_cnt_zero = (r_cnt == '0);

`ifdef LCD_BUSY_POLL_EN
  logic r_bf;
`else
  localparam logic [CNT_W-1:0] LD_WAIT      = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_WAIT_LONG = CNT_W'(40 * WAIT_CYCLES - 1);
  logic w_long_wait;
  // Clear-display and return-home need the long settle time.
  assign w_long_wait = !r_rs && ((r_byte == 8'h01) || (r_byte == 8'h02));
`endif

  sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (w_dout)
  );

  // FSM state, phase counter and the latched in-flight byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_byte  <= 8'h00;
`ifdef LCD_BUSY_POLL_EN
      r_bf    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) {r_rs, r_byte} <= w_dout;
`ifdef LCD_BUSY_POLL_EN
      if ((r_state == BF_EN) && w_cnt_zero) r_bf <= lcd_data_in[7];
`endif
    end
  end

  // Next-state and counter reload: each timed phase ends when the counter reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = SETUP;
        w_cnt_nxt   = LD_SETUP;
      end
      SETUP: if (w_cnt_zero) begin
        w_state_nxt = EN_HI;
        w_cnt_nxt   = LD_EN;
      end
      EN_HI: if (w_cnt_zero) begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = LD_HOLD;
      end
`ifdef LCD_BUSY_POLL_EN
      HOLD: if (w_cnt_zero) begin
        w_state_nxt = BF_SETUP;
        w_cnt_nxt   = LD_SETUP;
      end
      BF_SETUP: if (w_cnt_zero) begin
        w_state_nxt = BF_EN;
        w_cnt_nxt   = LD_EN;
      end
      BF_EN: if (w_cnt_zero) begin
        w_state_nxt = BF_HOLD;
        w_cnt_nxt   = LD_HOLD;
      end
      BF_HOLD: if (w_cnt_zero) begin
        w_state_nxt = r_bf ? BF_SETUP : IDLE;
        w_cnt_nxt   = LD_SETUP;
      end
`else
      HOLD: if (w_cnt_zero) begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = w_long_wait ? LD_WAIT_LONG : LD_WAIT;
      end
      WAIT: if (w_cnt_zero) begin
        w_state_nxt = IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pin decode from state; EN only in the pulse phases, busy-flag reads release DB.
  always_comb begin
    lcd_en       = (r_state == EN_HI) || (r_state == BF_EN);
    lcd_rs       = r_rs;
    lcd_rw       = 1'b0;
    lcd_data_oe  = 1'b1;
    lcd_data_out = r_byte;
    if ((r_state == BF_SETUP) || (r_state == BF_EN) || (r_state == BF_HOLD)) begin
      lcd_rs      = 1'b0;
      lcd_rw      = 1'b1;
      lcd_data_oe = 1'b0;
    end
  end

  // Sticky overflow (cleared by a STATUS read) and the CTRL register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf  <= 1'b0;
      r_ctrl <= 2'b00;
    end else begin
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_stat_rd) r_ovf <= 1'b0;
      if (w_wr && (bus.register_select == REG_CTRL)) r_ctrl <= bus.data_in[1:0];
    end
  end

  assign lcd_on   = r_ctrl[0];
  assign lcd_blon = r_ctrl[1];

  // CPU read mux, combinational from register_select.
  always_comb begin
    bus.data_out = 8'h00;
    case (bus.register_select)
      REG_STATUS: begin
        bus.data_out[STAT_FULL]  = w_full;
        bus.data_out[STAT_EMPTY] = w_empty;
        bus.data_out[STAT_BUSY]  = (r_state != IDLE);
        bus.data_out[STAT_OVF]   = r_ovf;
      end
      REG_CTRL: bus.data_out = {6'b0, r_ctrl};
      default:  bus.data_out = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_lcd_controller.sv
// Self-checking bench for lcd_controller: randomized bus traffic against a
// transaction-level model (byte queue plus engine-free time) and a pin monitor.
module tb_lcd_controller;
  import lcd_pkg::*;

  localparam int D = 16;
  localparam int S = 2;
  localparam int E = 12;
  localparam int H = 2;
  localparam int W = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] lcd_data_out, lcd_data_in;
  logic       lcd_data_oe, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon;

  always #5 clk = ~clk;

  lcd_controller_if bus();

  lcd_controller #(
    .FIFO_DEPTH(D), .SETUP_CYCLES(S), .EN_CYCLES(E), .HOLD_CYCLES(H), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .lcd_data_out(lcd_data_out), .lcd_data_in(lcd_data_in), .lcd_data_oe(lcd_data_oe),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_on(lcd_on), .lcd_blon(lcd_blon)
  );

  typedef struct {
    int         rise;
    bit         rs;
    bit         rw;
    bit         oe;
    logic [7:0] data;
  } pulse_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model state
  logic [8:0] m_q[$];
  pulse_t     m_exp[$];
  int         m_next_free = 0;
  bit         m_ovf = 1'b0;
  logic [1:0] m_ctrl = 2'b00;

  // monitor / LCD-side state
  bit         mon_en_prev;
  logic [10:0] mon_sig_prev;
  int         mon_last_chg, mon_rise, mon_fall;
  bit         mon_hold_pend;
  int         bf_n;
  int         cur_nb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycles one byte keeps the engine busy, from its pop to the return to idle.
  function automatic int xfer_len(input logic [8:0] e);
`ifdef LCD_BUSY_POLL_EN
    return (S + E + H) * (2 + int'(e[1:0]));
`else
    if (!e[8] && (e[7:0] == 8'h01 || e[7:0] == 8'h02)) return S + E + H + 40 * W;
    return S + E + H + W;
`endif
  endfunction

  function automatic logic [7:0] m_status();
    logic busy;
    busy = (cyc < m_next_free - 1);
    return {4'b0, m_ovf, busy, (m_q.size() == 0), (m_q.size() == D)};
  endfunction

  task automatic model_edge(input bit ce, input bit we, input logic [1:0] sel, input logic [7:0] d);
    logic [8:0] e;
    pulse_t p;
    if (cyc >= m_next_free && m_q.size() > 0) begin
      e = m_q.pop_front();
      m_next_free = cyc + xfer_len(e) + 1;
      p.rise = cyc + S; p.rs = e[8]; p.rw = 1'b0; p.oe = 1'b1; p.data = e[7:0];
      m_exp.push_back(p);
`ifdef LCD_BUSY_POLL_EN
      for (int k = 1; k <= int'(e[1:0]) + 1; k++) begin
        p.rise = cyc + k * (S + E + H) + S; p.rs = 1'b0; p.rw = 1'b1; p.oe = 1'b0; p.data = 8'h00;
        m_exp.push_back(p);
      end
`endif
    end
    if (ce && we && (sel == REG_CMD || sel == REG_DATA)) begin
      if (m_q.size() < D) m_q.push_back({(sel == REG_DATA), d});
      else m_ovf = 1'b1;
    end
    if (ce && we && sel == REG_CTRL) m_ctrl = d[1:0];
    if (ce && !we && sel == REG_STATUS) m_ovf = 1'b0;
  endtask

  task automatic mon_init();
    mon_en_prev   = lcd_en;
    mon_sig_prev  = {lcd_rs, lcd_rw, lcd_data_oe, lcd_data_out};
    mon_last_chg  = cyc;
    mon_hold_pend = 1'b0;
    bf_n = 0;
    cur_nb = 0;
  endtask

  task automatic monitor();
    logic [10:0] sig;
    pulse_t p;
    sig = {lcd_rs, lcd_rw, lcd_data_oe, lcd_data_out};
    chk("ctrl_pins", 32'({lcd_blon, lcd_on}), 32'(m_ctrl));
    if (sig !== mon_sig_prev) begin
      chk("sig_stable_around_en", 32'(lcd_en || mon_en_prev), 32'd0);
      if (mon_hold_pend) begin
        chk("hold_cycles_ok", 32'(cyc - mon_fall >= H), 32'd1);
        mon_hold_pend = 1'b0;
      end
      mon_last_chg = cyc;
      mon_sig_prev = sig;
    end
    if (lcd_en === 1'b1 && !mon_en_prev) begin
      chk("setup_cycles_ok", 32'(cyc - mon_last_chg >= S), 32'd1);
      chk("pulse_expected", 32'(m_exp.size() > 0), 32'd1);
      if (m_exp.size() > 0) begin
        p = m_exp.pop_front();
        chk("rise_cycle", cyc, p.rise);
        chk("rs", 32'(lcd_rs), 32'(p.rs));
        chk("rw", 32'(lcd_rw), 32'(p.rw));
        chk("oe", 32'(lcd_data_oe), 32'(p.oe));
        if (p.oe) chk("db", 32'(lcd_data_out), 32'(p.data));
        if (p.rw) begin
          bf_n++;
          lcd_data_in[7] = (bf_n <= cur_nb);
        end else begin
          bf_n = 0;
          cur_nb = int'(p.data[1:0]);
        end
      end
      mon_rise = cyc;
    end
    if (lcd_en === 1'b0 && mon_en_prev) begin
      chk("en_width", cyc - mon_rise, E);
      mon_fall = cyc;
      mon_hold_pend = 1'b1;
    end
    mon_en_prev = (lcd_en === 1'b1);
  endtask

  // One clock: drive bus just after negedge, check reads, run model for the edge, monitor pins.
  task automatic cycle(input bit ce, input bit we, input logic [1:0] sel, input logic [7:0] d);
    bus.chip_en = ce; bus.write_en = we; bus.register_select = sel; bus.data_in = d;
    #1;
    if (ce && !we) begin
      if (sel == REG_STATUS)    chk("status_rd", 32'(bus.data_out), 32'(m_status()));
      else if (sel == REG_CTRL) chk("ctrl_rd", 32'(bus.data_out), 32'({6'b0, m_ctrl}));
      else                      chk("cmd_data_rd", 32'(bus.data_out), 32'd0);
    end
    @(posedge clk);
    cyc++;
    model_edge(ce, we, sel, d);
    @(negedge clk);
    monitor();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    cycle(1'b1, 1'b1, sel, d);
  endtask

  task automatic rd(input logic [1:0] sel);
    cycle(1'b1, 1'b0, sel, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic drain();
    int g = 0;
    while ((m_q.size() != 0 || cyc < m_next_free - 1) && g < 5000) begin
      idle(1);
      g++;
    end
    chk("drain_bound", 32'(g < 5000), 32'd1);
    idle(3);
    chk("pulses_left", 32'(m_exp.size()), 32'd0);
    m_exp.delete();
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_en"},   32'(lcd_en), 32'd0);
    chk({tag, "_rs"},   32'(lcd_rs), 32'd0);
    chk({tag, "_rw"},   32'(lcd_rw), 32'd0);
    chk({tag, "_db"},   32'(lcd_data_out), 32'd0);
    chk({tag, "_oe"},   32'(lcd_data_oe), 32'd1);
    chk({tag, "_on"},   32'(lcd_on), 32'd0);
    chk({tag, "_blon"}, 32'(lcd_blon), 32'd0);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 chk("rst_en_async", 32'(lcd_en), 32'd0);
    m_q.delete(); m_exp.delete();
    m_next_free = 0; m_ovf = 1'b0; m_ctrl = 2'b00;
    bus.chip_en = 1'b0; bus.write_en = 1'b0;
    repeat (3) begin @(posedge clk); cyc++; end
    @(negedge clk);
    check_reset_pins("rst_mid");
    reset_n = 1'b1;
    mon_init();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [7:0] b;
    reset_n = 1'b0;
    bus.chip_en = 1'b0; bus.write_en = 1'b0; bus.register_select = 2'd0; bus.data_in = 8'h00;
    lcd_data_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_pins("rst");
    reset_n = 1'b1;
    mon_init();
    rd(REG_STATUS);

    // single command, busy visible while it plays out
    wr(REG_CMD, 8'h38);
    for (int i = 0; i < 20; i++) rd(REG_STATUS);
    drain();
    rd(REG_STATUS);

    // back-to-back data bytes
    wr(REG_DATA, 8'h41);
    wr(REG_DATA, 8'h42);
    drain();

    // control register and constant reads
    wr(REG_CTRL, 8'h03); rd(REG_CTRL);
    wr(REG_CTRL, 8'hFE); rd(REG_CTRL);
    rd(REG_CMD); rd(REG_DATA);
    wr(REG_STATUS, 8'hFF); rd(REG_STATUS);

    // long and short command waits
    wr(REG_CMD, 8'h01); wr(REG_CMD, 8'h06); wr(REG_DATA, 8'h55); wr(REG_CMD, 8'h02); wr(REG_DATA, 8'h43);
    drain();

    // fill past capacity behind a long clear, then clear the sticky overflow
    wr(REG_CMD, 8'h01);
    for (int i = 0; i < 17; i++) wr(REG_DATA, 8'($urandom));
    rd(REG_STATUS);
    rd(REG_STATUS);
    wr(REG_DATA, 8'h77);
    rd(REG_STATUS);
    drain();
    rd(REG_STATUS);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1: wr(REG_DATA, 8'($urandom));
        2: begin
          g = $urandom_range(0, 9);
          b = (g == 0) ? 8'h01 : (g == 1) ? 8'h02 : 8'($urandom);
          wr(REG_CMD, b);
        end
        3: rd(REG_STATUS);
        4: wr(REG_CTRL, 8'($urandom));
        5: rd(REG_CTRL);
        6: wr(REG_STATUS, 8'($urandom));
        7: rd(2'($urandom_range(0, 3)));
        default: idle($urandom_range(1, 30));
      endcase
    end
    drain();
    rd(REG_STATUS);

    // reset in the middle of an EN pulse with three bytes queued
    wr(REG_DATA, 8'h61); wr(REG_DATA, 8'h62); wr(REG_DATA, 8'h63); wr(REG_DATA, 8'h64);
    rd(REG_STATUS);
    g = 0;
    while (lcd_en !== 1'b1 && g < 50) begin idle(1); g++; end
    chk("en_seen_before_reset", 32'(lcd_en), 32'd1);
    idle(4);
    async_reset();
    rd(REG_STATUS);
    idle(200);
    rd(REG_STATUS);

    // traffic resumes normally after reset
    wr(REG_CMD, 8'h0C);
    wr(REG_DATA, 8'h5A);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
